// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-to-binary decode path.
`ifndef INWD
`define INWD 8
`endif
`ifndef NUM_RNG
`define NUM_RNG 4
`endif

package sc_pkg;

    localparam int unsigned INWD_DEF     = `INWD;
    localparam int unsigned NUM_RNG_DEF  = `NUM_RNG;
    localparam int unsigned WIN_LEN      = 1 << `INWD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } dec_state_t;

    typedef logic [`INWD:0] cnt_t;

endpackage

// File: rtl/sc_lane_counter.sv
// Per-lane ones counter: synchronous clear wins over increment.
module sc_lane_counter #(
    parameter int unsigned CW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Counts ones per lane over one 2^INWD-sample RNG period and hands the counts out on valid/ready.
`ifndef INWD
`define INWD 8
`endif
`ifndef NUM_RNG
`define NUM_RNG 4
`endif

module sc_bitstream_decoder
    import sc_pkg::*;
#(
    parameter int unsigned INWD     = `INWD,
    parameter int unsigned NUM_LANE = `NUM_RNG
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           clear,
    input  logic                           enable,
    input  logic [NUM_LANE-1:0]            bit_in,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANE-1:0][INWD:0]    value
);

    localparam int unsigned CW = INWD + 1;
    localparam logic [CW-1:0] LAST_SAMPLE = CW'((2 ** INWD) - 1);

    dec_state_t    state_q, state_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic          win_open_c;
    logic          sample_c;

    // State and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Next state; clear overrides every transition including a simultaneous start
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (enable && (sample_cnt_q == LAST_SAMPLE)) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = start ? ACCUM : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Status flags follow the state being entered so they line up with state_q
    always_comb begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = (state_d == ACCUM);
        valid_d = (state_d == HOLD);
    end

    assign win_open_c = (state_d == ACCUM) && (state_q != ACCUM);
    assign sample_c   = (state_q == ACCUM) && enable;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (clear || win_open_c) begin
            sample_cnt_d = '0;
        end else if (sample_c) begin
            sample_cnt_d = sample_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // Lane counters double as the output holding registers
    for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
        sc_lane_counter #(
            .CW (CW)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clear | win_open_c),
            .inc_i (sample_c & bit_in[l]),
            .cnt_o (value[l])
        );
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Randomized self-checking bench for sc_bitstream_decoder against a window-level ones-count model.
module tb_sc_bitstream_decoder;

    localparam int unsigned INWD = 8;
    localparam int unsigned NL   = 4;
    localparam int unsigned WIN  = 1 << INWD;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    clear = 1'b0;
    logic                    enable = 1'b0;
    logic                    out_ready = 1'b0;
    logic [NL-1:0]           bit_in = '0;
    logic                    busy;
    logic                    out_valid;
    logic [NL-1:0][INWD:0]   value;

    int total = 0;
    int bad   = 0;

    logic [NL-1:0] win_q[$];
    int            exp_cnt[NL];
    int            dir_exp[NL];

    always #5 clk = ~clk;

    sc_bitstream_decoder #(
        .INWD     (INWD),
        .NUM_LANE (NL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .enable    (enable),
        .bit_in    (bit_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value     (value)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [NL-1:0] dir_bits(input int n);
        logic [NL-1:0] b;
        b    = '0;
        b[0] = 1'b1;
        b[1] = 1'b0;
        b[2] = (n % 2 == 0);
        b[3] = (n % 4 == 0);
        return b;
    endfunction

    // Expected counts: ones among the first WIN enabled samples of the window
    function automatic void tally();
        for (int l = 0; l < NL; l++) exp_cnt[l] = 0;
        foreach (win_q[i]) begin
            for (int l = 0; l < NL; l++) exp_cnt[l] += int'(win_q[i][l]);
        end
    endfunction

    task automatic check_values(input string tag);
        tally();
        for (int l = 0; l < NL; l++)
            check($sformatf("%s_lane%0d", tag, l), 32'(value[l]), 32'(exp_cnt[l]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        for (int l = 0; l < NL; l++)
            check($sformatf("%s_val%0d", tag, l), 32'(value[l]), 32'd0);
    endtask

    // Start-cycle bits are all ones with enable high; none of them may be counted
    task automatic open_window();
        start     = 1'b1;
        out_ready = 1'b1;
        clear     = 1'b0;
        enable    = 1'b1;
        bit_in    = '1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        win_q.delete();
        check("open_busy", 32'(busy), 32'd1);
        check("open_valid", 32'(out_valid), 32'd0);
    endtask

    // mode 0: continuous directed, 1: one enable in four, 2: random, 3: all ones
    task automatic accum(input int mode, input int stop_at, output int lat);
        int            c;
        int            lat_exp;
        bit            done;
        logic          e;
        logic [NL-1:0] b;
        c       = 0;
        lat_exp = -1;
        done    = 1'b0;
        while (!done && c < 5000) begin
            if (stop_at >= 0 && win_q.size() == stop_at) begin
                done = 1'b1;
            end else begin
                case (mode)
                    0, 3:    e = 1'b1;
                    1:       e = (c % 4 == 3);
                    default: e = ($urandom % 3 != 0);
                endcase
                if (mode == 2)      b = NL'($urandom);
                else if (mode == 3) b = '1;
                else                b = e ? dir_bits(win_q.size()) : '1;
                enable = e;
                bit_in = b;
                start  = ($urandom % 6 == 0);
                if (e && win_q.size() < WIN) begin
                    win_q.push_back(b);
                    if (win_q.size() == WIN) lat_exp = c + 1;
                end
                tick();
                c++;
                if (out_valid === 1'b1) done = 1'b1;
            end
        end
        start  = 1'b0;
        enable = 1'b0;
        lat    = c;
        if (stop_at < 0) begin
            check("latency", 32'(c), 32'(lat_exp));
            check("hold_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic hold_stall(input int n);
        for (int i = 0; i < n; i++) begin
            enable    = 1'($urandom);
            bit_in    = NL'($urandom);
            start     = 1'($urandom);
            out_ready = 1'b0;
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_busy", 32'(busy), 32'd0);
            for (int l = 0; l < NL; l++)
                check($sformatf("stall_lane%0d", l), 32'(value[l]), 32'(exp_cnt[l]));
        end
        start = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_zero({tag, "_async"});
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enable = 1'b1;
            bit_in = NL'($urandom);
            tick();
        end
        check_zero({tag, "_after"});
    endtask

    initial begin
        int lat;
        dir_exp[0] = 256;
        dir_exp[1] = 0;
        dir_exp[2] = 128;
        dir_exp[3] = 64;

        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        check_zero("idle");

        // Continuous enable, directed lane patterns
        open_window();
        accum(0, -1, lat);
        check("lat_cont", 32'(lat), 32'd256);
        check_values("cont");
        for (int l = 0; l < NL; l++)
            check($sformatf("cont_const%0d", l), 32'(value[l]), 32'(dir_exp[l]));

        hold_stall(50);

        // Back-to-back start from HOLD, enable one cycle in four
        open_window();
        accum(1, -1, lat);
        check("lat_gated", 32'(lat), 32'd1024);
        check_values("gated");
        for (int l = 0; l < NL; l++)
            check($sformatf("gated_const%0d", l), 32'(value[l]), 32'(dir_exp[l]));

        // Plain handshake to IDLE keeps the last data
        out_ready = 1'b1;
        enable    = 1'b1;
        bit_in    = '1;
        tick();
        out_ready = 1'b0;
        check("hs_valid", 32'(out_valid), 32'd0);
        check("hs_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        check_values("idle_keep");

        // Clear at sample 100, then a clean all-ones window
        open_window();
        accum(3, 100, lat);
        clear  = 1'b1;
        enable = 1'b1;
        bit_in = '1;
        tick();
        clear = 1'b0;
        check_zero("clear");
        open_window();
        accum(3, -1, lat);
        check_values("ones");
        for (int l = 0; l < NL; l++)
            check($sformatf("ones_const%0d", l), 32'(value[l]), 32'(WIN));

        // start together with clear in IDLE opens nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start  = 1'b1;
        clear  = 1'b1;
        enable = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        check_zero("start_clear");
        repeat (10) begin
            bit_in = NL'($urandom);
            tick();
        end
        check_zero("start_clear_idle");

        // Random windows, chained back to back
        for (int w = 0; w < 3; w++) begin
            open_window();
            accum(2, -1, lat);
            check_values($sformatf("rand%0d", w));
        end

        async_reset("rst_hold");

        open_window();
        accum(2, 60, lat);
        async_reset("rst_accum");

        open_window();
        accum(2, -1, lat);
        check_values("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
